// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the MIPS ALU: decodes R/I-type ALU ops into the ALU
// control code, reads operands from a 32x32 register file (with writeback
// bypass) and holds the result in a single registered valid/ready slot.
module alu_operand_stage #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_aluctl,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [4:0]       out_dest,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [NREGS-1:0][WIDTH-1:0] regs;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign imm    = in_instr[15:0];
  assign funct  = in_instr[5:0];

  logic             accept;
  logic             dec_legal;
  logic [3:0]       dec_ctl;
  logic [WIDTH-1:0] dec_b;
  logic [4:0]       dec_dest;
  logic [WIDTH-1:0] rs_val, rt_val;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand read: r0 is hard zero, a same-cycle writeback wins over the array.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (wb_en && wb_addr == rs) rs_val = wb_data;
    if (wb_en && wb_addr == rt) rt_val = wb_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  // Instruction decode into ALU control, B operand and destination.
  always_comb begin
    dec_legal = 1'b0;
    dec_ctl   = 4'd0;
    dec_b     = rt_val;
    dec_dest  = rd;
    if (opcode == OP_RTYPE) begin
      dec_legal = 1'b1;
      case (funct)
        FN_AND:  dec_ctl = 4'd0;
        FN_OR:   dec_ctl = 4'd1;
        FN_ADD:  dec_ctl = 4'd2;
        FN_SUB:  dec_ctl = 4'd6;
        FN_SLT:  dec_ctl = 4'd7;
        FN_NOR:  dec_ctl = 4'd12;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_legal = 1'b1;
      dec_dest  = rt;
      case (opcode)
        OP_ADDI: begin dec_ctl = 4'd2; dec_b = {{(WIDTH-16){imm[15]}}, imm}; end
        OP_SLTI: begin dec_ctl = 4'd7; dec_b = {{(WIDTH-16){imm[15]}}, imm}; end
        OP_ANDI: begin dec_ctl = 4'd0; dec_b = {{(WIDTH-16){1'b0}}, imm}; end
        OP_ORI:  begin dec_ctl = 4'd1; dec_b = {{(WIDTH-16){1'b0}}, imm}; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Output slot: load on legal accept, drain on out_ready, otherwise hold.
  // An accepted illegal op only happens when the slot is empty or draining,
  // so it falls into the drain branch and leaves the slot empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_aluctl <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_dest   <= '0;
      illegal    <= 1'b0;
    end else begin
      illegal <= accept && !dec_legal;
      if (accept && dec_legal) begin
        out_valid  <= 1'b1;
        out_aluctl <= dec_ctl;
        out_a      <= rs_val;
        out_b      <= dec_b;
        out_dest   <= dec_dest;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected slot contents are queued
// when an instruction is accepted and compared when the ALU consumes the slot.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_aluctl;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_dest;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        illegal;

  alu_operand_stage #(.NREGS(32), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluctl(out_aluctl), .out_a(out_a), .out_b(out_b), .out_dest(out_dest),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Consume side: every valid&&ready cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ctl",  {28'd0, out_aluctl}, {28'd0, e.ctl});
        chk("a",    out_a, e.a);
        chk("b",    out_b, e.b);
        chk("dest", {27'd0, out_dest}, {27'd0, e.dest});
      end
    end
  end

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    step();
    wb_en = 1'b0;
  endtask

  // Present one instruction, wait (bounded) for acceptance, queue expectation.
  task automatic issue(input logic [31:0] instr, input bit legal,
                       input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] dest);
    exp_t e;
    bit   ok = 0;
    in_valid = 1'b1; in_instr = instr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (legal) begin
      e.ctl = ctl; e.a = a; e.b = b; e.dest = dest;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
    wb_en = 1'b0;
    if (legal) chk("issued_valid", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_illegal",   {31'd0, illegal}, 32'd0);
    chk("rst_out_a",     out_a, 32'd0);
    chk("rst_out_b",     out_b, 32'd0);
    chk("rst_ctl_dest",  {23'd0, out_aluctl, out_dest}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();

    // R-type through the whole funct table
    wb(5'd1, 32'h5555_5555);
    wb(5'd2, 32'hAAAA_AAAB);
    issue(32'h0022_1820, 1, 4'd2,  32'h5555_5555, 32'hAAAA_AAAB, 5'd3);
    issue(32'h0022_182A, 1, 4'd7,  32'h5555_5555, 32'hAAAA_AAAB, 5'd3);
    issue(32'h0022_1827, 1, 4'd12, 32'h5555_5555, 32'hAAAA_AAAB, 5'd3);
    issue(32'h0022_1824, 1, 4'd0,  32'h5555_5555, 32'hAAAA_AAAB, 5'd3);
    issue(32'h0022_1825, 1, 4'd1,  32'h5555_5555, 32'hAAAA_AAAB, 5'd3);
    issue(32'h0022_1822, 1, 4'd6,  32'h5555_5555, 32'hAAAA_AAAB, 5'd3);

    // I-type: sign vs zero extension
    issue(32'h2024_FFFF, 1, 4'd2, 32'h5555_5555, 32'hFFFF_FFFF, 5'd4);
    issue(32'h3025_8000, 1, 4'd0, 32'h5555_5555, 32'h0000_8000, 5'd5);
    issue(32'h2826_FFFE, 1, 4'd7, 32'h5555_5555, 32'hFFFF_FFFE, 5'd6);
    issue(32'h3427_8001, 1, 4'd1, 32'h5555_5555, 32'h0000_8001, 5'd7);

    // r0 stays zero; same-cycle bypass on rs and rt; no bypass onto r0
    wb(5'd0, 32'h1234_5678);
    issue(32'h0000_1820, 1, 4'd2, 32'h0, 32'h0, 5'd3);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD_BEEF;
    issue(32'h0022_1820, 1, 4'd2, 32'hDEAD_BEEF, 32'hAAAA_AAAB, 5'd3);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0123_4567;
    issue(32'h0022_1820, 1, 4'd2, 32'hDEAD_BEEF, 32'h0123_4567, 5'd3);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_0000;
    issue(32'h0000_1820, 1, 4'd2, 32'h0, 32'h0, 5'd3);

    // Back-to-back with out_ready=1: each issue takes one cycle
    for (int i = 0; i < 4; i++)
      issue(32'h2024_0000 | i, 1, 4'd2, 32'hDEAD_BEEF, i, 5'd4);
    step(); step();

    // Backpressure: slot held, second instruction stalled, writes ignored
    out_ready = 1'b0;
    issue(32'h0022_1822, 1, 4'd6, 32'hDEAD_BEEF, 32'h0123_4567, 5'd3);
    in_valid = 1'b1; in_instr = 32'h0022_1825;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h1111_1111;
    step();
    wb_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_valid",    {31'd0, out_valid}, 32'd1);
      chk("hold_a",        out_a, 32'hDEAD_BEEF);
      chk("hold_b",        out_b, 32'h0123_4567);
      chk("hold_ctl",      {28'd0, out_aluctl}, 32'd6);
    end
    step();
    begin
      exp_t e;
      e.ctl = 4'd1; e.a = 32'h1111_1111; e.b = 32'h0123_4567; e.dest = 5'd3;
      out_ready = 1'b1;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
    chk("released_valid", {31'd0, out_valid}, 32'd1);
    step();

    // Unsupported opcode and funct: one-cycle illegal pulse, slot stays empty
    issue(32'h8C00_0000, 0, 4'd0, 32'h0, 32'h0, 5'd0);
    chk("lw_illegal", {31'd0, illegal}, 32'd1);
    chk("lw_valid",   {31'd0, out_valid}, 32'd0);
    step();
    chk("lw_illegal_drop", {31'd0, illegal}, 32'd0);
    issue(32'h0022_1821, 0, 4'd0, 32'h0, 32'h0, 5'd0);
    chk("addu_illegal", {31'd0, illegal}, 32'd1);
    chk("addu_valid",   {31'd0, out_valid}, 32'd0);
    step();

    // Asynchronous reset with the slot full
    out_ready = 1'b0;
    issue(32'h0022_1820, 1, 4'd2, 32'h1111_1111, 32'h0123_4567, 5'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_a",     out_a, 32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(32'h0022_1820, 1, 4'd2, 32'h0, 32'h0, 5'd3);

    // Drain scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("sb_drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
